// File: rtl/uart_pkg.sv
// Shared UART-side definitions for the sorter's transmit buffer and receive assembler.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package uart_pkg;

    localparam int BYTE_W = 8;

    // Default sorter geometry; seq_t is the sequence shape exchanged with the sorter.
    localparam int SEQ_WIDTH = 32;
    localparam int SEQ_DEPTH = 8;

    typedef logic [SEQ_DEPTH-1:0][SEQ_WIDTH-1:0] seq_t;

    // Bytes per word of the given bit width.
    function automatic int bpw(input int width);
        return width / BYTE_W;
    endfunction

    // Counter/index width that stays at least one bit for degenerate sizes.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_fifo.sv
// Circular FIFO of complete DEPTH x WIDTH sequences, NUM_SEQ entries deep.
// Latency: a push is visible at rd_data/valid_out on the next clk edge.
// Backpressure: pops on valid_out && ready_in; a push into a full FIFO is accepted
// only if a pop happens in the same cycle, otherwise it is dropped and flagged.
// Ports: clk, rst (async, active-high); push/push_data in; ready_in in;
//        rd_data/valid_out/level out; dropped out (combinational, same cycle as push).
module seq_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int NUM_SEQ = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic [DEPTH-1:0][WIDTH-1:0]      push_data,
    input  logic                             ready_in,
    output logic [DEPTH-1:0][WIDTH-1:0]      rd_data,
    output logic                             valid_out,
    output logic [$clog2(NUM_SEQ+1)-1:0]     level,
    output logic                             dropped
);

    localparam int PTR_W = idx_w(NUM_SEQ);
    localparam int LVL_W = $clog2(NUM_SEQ+1);

    logic [DEPTH-1:0][WIDTH-1:0] mem [NUM_SEQ];
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;
    logic [LVL_W-1:0]            level_q;
    logic                        pop;
    logic                        accept;

    assign pop     = (level_q != '0) && ready_in;
    // A full FIFO can still take the push when the head leaves in the same cycle.
    assign accept  = push && ((level_q < LVL_W'(NUM_SEQ)) || pop);
    assign dropped = push && !accept;

    assign valid_out = (level_q != '0);
    assign level     = level_q;
    assign rd_data   = mem[rd_ptr];

    // Storage has no reset; the rst gate keeps a reset cycle from writing it.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= (wr_ptr == PTR_W'(NUM_SEQ-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(NUM_SEQ-1)) ? '0 : rd_ptr + 1'b1;
            end
            if (accept && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !accept) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/rx_assembler.sv
// Reassembles UART bytes into WIDTH-bit words and DEPTH-word sequences for the sorter.
// Latency: valid_out rises one clk after the strobe of a sequence's final byte.
// Backpressure: valid/ready on array_out; NUM_SEQ sequences buffered, further
// completed sequences are dropped with an overflow pulse (bytes are never stalled).
// Ports: clk, rst (async, active-high); byte_in/byte_valid/rx_error from the UART
//        receiver; array_out/valid_out/ready_in to the sorter; level, overflow, resync status.
module rx_assembler
    import uart_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int NUM_SEQ = 4,
    parameter int TIMEOUT = 100000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [BYTE_W-1:0]                byte_in,
    input  logic                             byte_valid,
    input  logic                             rx_error,
    output logic [DEPTH-1:0][WIDTH-1:0]      array_out,
    output logic                             valid_out,
    input  logic                             ready_in,
    output logic [$clog2(NUM_SEQ+1)-1:0]     level,
    output logic                             overflow,
    output logic                             resync
);

    localparam int BPW    = bpw(WIDTH);
    localparam int WIDX_W = idx_w(DEPTH);
    localparam int BIDX_W = idx_w(BPW);
    localparam int CNT_W  = $clog2(TIMEOUT+1);

    logic [DEPTH-1:0][WIDTH-1:0] staging;
    logic [DEPTH-1:0][WIDTH-1:0] merged;
    logic [WIDX_W-1:0]           word_idx;
    logic [BIDX_W-1:0]           byte_idx;
    logic [CNT_W-1:0]            idle_cnt;

    logic in_prog;
    logic last_byte;
    logic take;
    logic complete;
    logic timeout_hit;
    logic discard;
    logic dropped;

    // Any index away from its start value means at least one byte is held.
    assign in_prog     = (word_idx != WIDX_W'(DEPTH-1)) || (byte_idx != '0);
    assign last_byte   = (word_idx == '0) && (byte_idx == BIDX_W'(BPW-1));
    assign take        = byte_valid && !rx_error;
    assign complete    = take && last_byte;
    // Fires on the idle cycle that would bring the counter to TIMEOUT.
    assign timeout_hit = in_prog && !byte_valid && (idle_cnt == CNT_W'(TIMEOUT-1));
    assign discard     = (rx_error && in_prog) || timeout_hit;

    // Final byte folded in so the pushed sequence is whole in the completing cycle.
    always_comb begin
        merged = staging;
        merged[word_idx][byte_idx*BYTE_W +: BYTE_W] = byte_in;
    end

    always_ff @(posedge clk) begin
        if (take && !rst) begin
            staging[word_idx][byte_idx*BYTE_W +: BYTE_W] <= byte_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_idx <= WIDX_W'(DEPTH-1);
            byte_idx <= '0;
            idle_cnt <= '0;
            overflow <= 1'b0;
            resync   <= 1'b0;
        end else begin
            overflow <= dropped;
            resync   <= discard;

            if (rx_error || timeout_hit) begin
                word_idx <= WIDX_W'(DEPTH-1);
                byte_idx <= '0;
            end else if (byte_valid) begin
                if (byte_idx == BIDX_W'(BPW-1)) begin
                    byte_idx <= '0;
                    word_idx <= (word_idx == '0) ? WIDX_W'(DEPTH-1) : word_idx - 1'b1;
                end else begin
                    byte_idx <= byte_idx + 1'b1;
                end
            end

            if (!in_prog || byte_valid || rx_error || timeout_hit) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    seq_fifo #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .NUM_SEQ (NUM_SEQ)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (complete),
        .push_data (merged),
        .ready_in  (ready_in),
        .rd_data   (array_out),
        .valid_out (valid_out),
        .level     (level),
        .dropped   (dropped)
    );

endmodule

// File: tb/tb_rx_assembler.sv
// Randomised bench for rx_assembler against a queue-based model of the byte stream.
// Latency: model predicts registered outputs one clk after each sampled input set.
// Backpressure: ready_in is driven by the directed scenarios and randomly in the soak.
module tb_rx_assembler;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 8;
    localparam int NUM_SEQ = 4;
    localparam int TIMEOUT = 50;
    localparam int BPW     = WIDTH / 8;
    localparam int NB      = DEPTH * BPW;

    typedef logic [DEPTH-1:0][WIDTH-1:0] arr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       rx_error = 1'b0;
    logic       ready_in = 1'b0;
    arr_t       array_out;
    logic       valid_out;
    logic [2:0] level;
    logic       overflow;
    logic       resync;

    always #5 clk = ~clk;

    rx_assembler #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .NUM_SEQ (NUM_SEQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .rx_error   (rx_error),
        .array_out  (array_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .level      (level),
        .overflow   (overflow),
        .resync     (resync)
    );

    int vectors     = 0;
    int miscompares = 0;
    int ovf_cnt     = 0;
    int rs_cnt      = 0;

    // Model: bytes of the current partial sequence, stored sequences, idle count.
    logic [7:0] m_part [$];
    arr_t       m_fifo [$];
    int         m_idle = 0;
    logic       m_ovf  = 1'b0;
    logic       m_rs   = 1'b0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_part.delete();
            m_fifo.delete();
            m_idle = 0;
            m_ovf  = 1'b0;
            m_rs   = 1'b0;
        end else begin : step
            logic pop;
            logic push;
            arr_t s;
            pop    = (m_fifo.size() > 0) && ready_in;
            push   = 1'b0;
            m_ovf  = 1'b0;
            m_rs   = 1'b0;
            s      = '0;
            if (rx_error) begin
                if (m_part.size() > 0) m_rs = 1'b1;
                m_part.delete();
                m_idle = 0;
            end else if (byte_valid) begin
                m_part.push_back(byte_in);
                m_idle = 0;
                if (m_part.size() == NB) begin
                    // k-th byte lands in element DEPTH-1-k/BPW, lane k%BPW.
                    for (int k = 0; k < NB; k++) begin
                        s[DEPTH-1-k/BPW][8*(k%BPW) +: 8] = m_part[k];
                    end
                    m_part.delete();
                    if (m_fifo.size() < NUM_SEQ || pop) push = 1'b1;
                    else m_ovf = 1'b1;
                end
            end else if (m_part.size() > 0) begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    m_rs = 1'b1;
                    m_part.delete();
                    m_idle = 0;
                end
            end
            if (pop) void'(m_fifo.pop_front());
            if (push) m_fifo.push_back(s);
        end
    end

    always @(negedge clk) begin
        chk("valid_out", valid_out, m_fifo.size() != 0);
        chk("level", level, m_fifo.size());
        chk("overflow", overflow, m_ovf);
        chk("resync", resync, m_rs);
        if (m_fifo.size() > 0) chk("array_out", array_out, m_fifo[0]);
        if (overflow === 1'b1) ovf_cnt++;
        if (resync === 1'b1) rs_cnt++;
    end

    // Called at a negedge; holds the inputs through one posedge and returns at the next negedge.
    task automatic drive(input logic bv, input logic [7:0] b, input logic err, input logic rdy);
        byte_valid = bv;
        byte_in    = b;
        rx_error   = err;
        ready_in   = rdy;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, rdy);
    endtask

    task automatic send_bytes(input arr_t s, input int from, input int to, input logic rdy,
                              input logic last_rdy);
        for (int k = from; k < to; k++) begin
            drive(1'b1, s[DEPTH-1-k/BPW][8*(k%BPW) +: 8], 1'b0, (k == NB-1) ? last_rdy : rdy);
        end
    endtask

    function automatic arr_t rand_seq();
        arr_t s;
        for (int i = 0; i < DEPTH; i++) s[i] = $urandom;
        return s;
    endfunction

    initial begin
        arr_t s;
        arr_t nw;
        arr_t saved [5];
        @(negedge clk);
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_level", level, 3'd0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_resync", resync, 1'b0);
        rst = 1'b0;
        idle(2, 1'b0);

        // Loopback: element i = {4{i}}.
        for (int i = 0; i < DEPTH; i++) s[i] = {4{i[7:0]}};
        for (int k = 0; k < NB; k++) begin
            drive(1'b1, s[DEPTH-1-k/BPW][8*(k%BPW) +: 8], 1'b0, 1'b1);
            if (k == NB-2) chk("lb_not_early", valid_out, 1'b0);
        end
        chk("lb_valid", valid_out, 1'b1);
        chk("lb_elem7", array_out[7], 32'h07070707);
        chk("lb_elem0", array_out[0], 32'h00000000);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("lb_popped", level, 3'd0);

        // Overflow: five sequences, no reads.
        ovf_cnt = 0;
        for (int j = 0; j < 5; j++) begin
            saved[j] = rand_seq();
            send_bytes(saved[j], 0, NB, 1'b0, 1'b0);
        end
        idle(1, 1'b0);
        chk("ovf_level", level, 3'd4);
        chk("ovf_pulses", ovf_cnt, 1);
        for (int j = 0; j < 4; j++) begin
            chk("ovf_readback", array_out, saved[j]);
            drive(1'b0, 8'h00, 1'b0, 1'b1);
        end
        chk("ovf_drained", level, 3'd0);

        // Simultaneous push and pop at full.
        for (int j = 0; j < 4; j++) begin
            saved[j] = rand_seq();
            send_bytes(saved[j], 0, NB, 1'b0, 1'b0);
        end
        ovf_cnt = 0;
        nw = rand_seq();
        send_bytes(nw, 0, NB, 1'b0, 1'b1);
        idle(1, 1'b0);
        chk("pp_no_ovf", ovf_cnt, 0);
        chk("pp_level", level, 3'd4);
        for (int j = 1; j < 4; j++) begin
            chk("pp_readback", array_out, saved[j]);
            drive(1'b0, 8'h00, 1'b0, 1'b1);
        end
        chk("pp_tail", array_out, nw);
        drive(1'b0, 8'h00, 1'b0, 1'b1);

        // Framing error after 10 bytes.
        rs_cnt = 0;
        s = rand_seq();
        send_bytes(s, 0, 10, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        s = rand_seq();
        send_bytes(s, 0, NB, 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("fe_resync", rs_cnt, 1);
        chk("fe_level", level, 3'd1);
        chk("fe_data", array_out, s);
        drive(1'b0, 8'h00, 1'b0, 1'b1);

        // Timeout: 5 bytes then TIMEOUT idle cycles.
        rs_cnt = 0;
        s = rand_seq();
        send_bytes(s, 0, 5, 1'b0, 1'b0);
        idle(TIMEOUT + 1, 1'b0);
        chk("to_resync", rs_cnt, 1);
        s = rand_seq();
        send_bytes(s, 0, NB, 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("to_level", level, 3'd1);
        chk("to_data", array_out, s);
        drive(1'b0, 8'h00, 1'b0, 1'b1);

        // One idle cycle short of the timeout keeps the partial sequence.
        rs_cnt = 0;
        s = rand_seq();
        send_bytes(s, 0, 5, 1'b0, 1'b0);
        idle(TIMEOUT - 1, 1'b0);
        send_bytes(s, 5, NB, 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("to49_no_resync", rs_cnt, 0);
        chk("to49_data", array_out, s);
        drive(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset with two stored sequences and seven staged bytes.
        for (int j = 0; j < 2; j++) send_bytes(rand_seq(), 0, NB, 1'b0, 1'b0);
        send_bytes(rand_seq(), 0, 7, 1'b0, 1'b0);
        byte_valid = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rr_valid", valid_out, 1'b0);
        chk("rr_level", level, 3'd0);
        chk("rr_overflow", overflow, 1'b0);
        chk("rr_resync", resync, 1'b0);
        rst = 1'b0;
        idle(1, 1'b0);
        s = rand_seq();
        send_bytes(s, 0, NB, 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("rr_level_after", level, 3'd1);
        chk("rr_data", array_out, s);
        drive(1'b0, 8'h00, 1'b0, 1'b1);

        // Random soak: every cycle is checked against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                idle(TIMEOUT + $urandom_range(0, 5), $urandom_range(0, 1) == 0);
            end else begin
                drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 199) == 0,
                      $urandom_range(0, 3) == 0);
            end
        end
        idle(4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 1000000", $time);
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule
